// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Constants and FSM state type shared by the byte FIFO and its
//               write-side arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int c_FIFO_DEPTH  = 8;
  localparam int c_FIFO_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; the first valid requester
//               found scanning upward from ptr+1 (with wrap) wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int w_j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_j   = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(ptr) + k) % N;
      if (!any && valid[w_j]) begin
        any        = 1'b1;
        grant[w_j] = 1'b1;
        idx        = IDX_W'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin write-port arbiter with credit-based occupancy
//               tracking; optional burst hold via FIFO_ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = c_FIFO_DATA_W,
  parameter int DEPTH     = c_FIFO_DEPTH,
  parameter int BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_write_enable,
  output logic [DATA_W-1:0]            fifo_data_in,
  input  logic                         fifo_read_done,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         overflow_err
);

  localparam int c_IDX_W  = $clog2(NUM_REQ);
  localparam int c_CRED_W = $clog2(DEPTH + 1);
`ifdef FIFO_ARB_BURST_EN
  localparam int         c_BURST_W = $clog2(BURST_MAX + 1);
  localparam arb_state_t c_BUSY_ST = HOLD;
`else
  localparam arb_state_t c_BUSY_ST = ACTIVE;
`endif

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_MAX < 1) begin : g_param_check
      $error("fifo_write_arbiter: unsupported NUM_REQ or BURST_MAX");
    end
  endgenerate

  arb_state_t            r_state, w_state_next;
  logic [c_IDX_W-1:0]    r_ptr, r_grant_id, w_accept_idx, w_pick_idx;
  logic [NUM_REQ-1:0]    w_pick_onehot;
  logic                  w_pick_any, w_hold_accept, w_accept;
  logic                  w_overflow_evt, w_rd_credit;
  logic [c_CRED_W-1:0]   r_credits, w_credits_next;
  logic                  r_we, r_overflow;
  logic [DATA_W-1:0]     r_data, w_accept_data;
`ifdef FIFO_ARB_BURST_EN
  logic [c_BURST_W-1:0]  r_burst_cnt, w_burst_cnt_next;
`endif

  rr_pick #(.N(NUM_REQ), .IDX_W(c_IDX_W)) u_rr_pick (
    .valid (req_valid),
    .ptr   (r_ptr),
    .grant (w_pick_onehot),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  always_comb begin
    w_hold_accept = 1'b0;
    w_accept_idx  = w_pick_idx;
    req_ready     = '0;
`ifdef FIFO_ARB_BURST_EN
    // The last winner (held in r_ptr) keeps priority for up to BURST_MAX beats.
    if (r_state == HOLD && req_valid[r_ptr] &&
        r_burst_cnt < c_BURST_W'(BURST_MAX)) begin
      w_hold_accept = 1'b1;
      w_accept_idx  = r_ptr;
    end
`endif
    w_accept = !reset && (r_credits != '0) && (w_hold_accept || w_pick_any);
    if (w_accept) begin
      if (w_hold_accept) req_ready[r_ptr] = 1'b1;
      else               req_ready = w_pick_onehot;
    end
    w_accept_data = req_data[int'(w_accept_idx)*DATA_W +: DATA_W];

    // A pop while the FIFO is already empty is a consumer bug, not a credit.
    w_overflow_evt = fifo_read_done && !w_accept && (r_credits == c_CRED_W'(DEPTH));
    w_rd_credit    = fifo_read_done && !w_overflow_evt;
    w_credits_next = r_credits;
    if (w_accept && !w_rd_credit)      w_credits_next = r_credits - c_CRED_W'(1);
    else if (!w_accept && w_rd_credit) w_credits_next = r_credits + c_CRED_W'(1);

    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = c_BUSY_ST;
      default: w_state_next = w_accept ? c_BUSY_ST : IDLE;
    endcase
`ifdef FIFO_ARB_BURST_EN
    w_burst_cnt_next = '0;
    if (w_hold_accept) w_burst_cnt_next = r_burst_cnt + c_BURST_W'(1);
    else if (w_accept) w_burst_cnt_next = c_BURST_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= c_IDX_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_credits  <= c_CRED_W'(DEPTH);
      r_we       <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
      r_burst_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_credits <= w_credits_next;
      r_we      <= w_accept;
      if (w_overflow_evt) r_overflow <= 1'b1;
      if (w_accept) begin
        r_ptr      <= w_accept_idx;
        r_grant_id <= w_accept_idx;
        r_data     <= w_accept_data;
      end
`ifdef FIFO_ARB_BURST_EN
      r_burst_cnt <= w_burst_cnt_next;
`endif
    end
  end

  assign fifo_write_enable = r_we;
  assign fifo_data_in      = r_data;
  assign credits           = r_credits;
  assign grant_id          = r_grant_id;
  assign overflow_err      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed vector bench for fifo_write_arbiter (4 req, 8 deep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_write_enable;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_read_done;
  logic [3:0]    credits;
  logic [1:0]    grant_id;
  logic          overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(8), .BURST_MAX(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .fifo_write_enable (fifo_write_enable),
    .fifo_data_in      (fifo_data_in),
    .fifo_read_done    (fifo_read_done),
    .credits           (credits),
    .grant_id          (grant_id),
    .overflow_err      (overflow_err)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       rd;
    logic [3:0] rdy;
    logic       we;
    logic       chk_d;
    logic [7:0] d;
    logic [3:0] cr;
    logic [1:0] gid;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic rd);
    @(negedge clk);
    reset          = r;
    req_valid      = v;
    fifo_read_done = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 1'b0);
    tick();
  endtask

`ifndef FIFO_ARB_BURST_EN
  vec_t tbl [12];
`endif

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    fifo_read_done = 1'b0;
    req_data       = {8'h33, 8'h22, 8'h11, 8'hA5};

`ifndef FIFO_ARB_BURST_EN
    //            rst   vld      rd    rdy      we    chk_d d      cr    gid   ovf
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 8'h00, 4'd8, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'hA5, 4'd7, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'd7, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h11, 4'd6, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 8'h33, 4'd5, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA5, 4'd5, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'd6, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h22, 4'd5, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 8'h00, 4'd8, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'd8, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 8'h33, 4'd7, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 8'h00, 4'd8, 2'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].rd);
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d write_enable", i), 32'(fifo_write_enable), 32'(tbl[i].we));
      if (tbl[i].chk_d)
        chk($sformatf("vec%0d data_in", i), 32'(fifo_data_in), 32'(tbl[i].d));
      chk($sformatf("vec%0d credits", i), 32'(credits), 32'(tbl[i].cr));
      chk($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("vec%0d overflow", i), 32'(overflow_err), 32'(tbl[i].ovf));
    end
`endif

    // Fill to full from requester 2 alone: 8 accepts, then blocked.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 4'b0100, 1'b0);
      chk($sformatf("fill%0d req_ready", c), 32'(req_ready), (c < 8) ? 32'h4 : 32'h0);
      tick();
      chk($sformatf("fill%0d write_enable", c), 32'(fifo_write_enable), (c < 8) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d credits", c), 32'(credits), (c < 8) ? 32'(7 - c) : 32'd0);
    end

    // Empty credits with a pop and a request in the same cycle.
    drive(1'b0, 4'b0100, 1'b1);
    chk("zero_cred req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("zero_cred credits", 32'(credits), 32'd1);
    chk("zero_cred write_enable", 32'(fifo_write_enable), 32'd0);
    drive(1'b0, 4'b0100, 1'b0);
    chk("after_pop req_ready", 32'(req_ready), 32'h4);
    tick();
    chk("after_pop credits", 32'(credits), 32'd0);
    chk("after_pop write_enable", 32'(fifo_write_enable), 32'd1);
    chk("after_pop data_in", 32'(fifo_data_in), 32'h22);

`ifndef FIFO_ARB_BURST_EN
    // Fairness: all requesters valid, pop every cycle after the first write.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b1111, (c == 0) ? 1'b0 : 1'b1);
      chk($sformatf("fair%0d req_ready", c), 32'(req_ready), 32'(1) << (c % 4));
      tick();
      chk($sformatf("fair%0d grant_id", c), 32'(grant_id), 32'(c % 4));
      chk($sformatf("fair%0d credits", c), 32'(credits), 32'd7);
    end
`else
    // Burst: requesters 0 and 1 valid, each holds the port for four beats.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, 4'b0011, (c == 0) ? 1'b0 : 1'b1);
      tick();
      chk($sformatf("burst%0d grant_id", c), 32'(grant_id), ((c / 4) % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d write_enable", c), 32'(fifo_write_enable), 32'd1);
    end
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'b0011, 1'b0);
      tick();
      chk($sformatf("drop%0d grant_id", c), 32'(grant_id), 32'd0);
    end
    drive(1'b0, 4'b0010, 1'b0);
    chk("drop req_ready", 32'(req_ready), 32'h2);
    tick();
    chk("drop grant_id", 32'(grant_id), 32'd1);
`endif

    drive(1'b0, 4'b0000, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
